// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
//   - WIDTH / AMT_W   : default operand width and shift-amount width
//   - OP_*            : operation codes presented on the op input
//   - state_e         : control state encoding
//   - uses_amount()   : whether an op code consumes the shift amount
// Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR op codes).
package shift_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned AMT_W = 5;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_SRA  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   // Ops outside this set behave as LOAD, so their amount is treated as 0.
   function automatic logic uses_amount(logic [2:0] op);
      case (op)
         OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef SHIFT_ROTATE_EN
         OP_ROL, OP_ROR: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/shift_if.sv
// Request/response bundle between the control unit and the shifter.
//   master (controller): drives start, op, data_in, amount; reads result, busy, done
//   slave  (shifter)   : reads start, op, data_in, amount; drives result, busy, done
interface shift_if #(
   parameter int unsigned WIDTH = shift_pkg::WIDTH,
   parameter int unsigned AMT_W = shift_pkg::AMT_W
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] data_in;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   modport master (
      output start, op, data_in, amount,
      input  result, busy, done
   );

   modport slave (
      input  start, op, data_in, amount,
      output result, busy, done
   );
endinterface

// File: rtl/shift_step.sv
// Combinational one-bit step of the working value for a given op code.
//   op      : latched operation code
//   value   : current working value
//   stepped : value advanced by one bit position
// ROL/ROR steps exist only when SHIFT_ROTATE_EN is defined; otherwise those
// codes (like LOAD and 110/111) pass the value through unchanged.
module shift_step #(
   parameter int unsigned WIDTH = shift_pkg::WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] stepped
);
   import shift_pkg::*;

   always_comb begin
      stepped = value;
      case (op)
         OP_SLL: stepped = {value[WIDTH-2:0], 1'b0};
         OP_SRL: stepped = {1'b0, value[WIDTH-1:1]};
         // Fill from the current top bit, so repeated steps replicate the sign.
         OP_SRA: stepped = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
         OP_ROL: stepped = {value[WIDTH-2:0], value[WIDTH-1]};
         OP_ROR: stepped = {value[0], value[WIDTH-1:1]};
`endif
         default: stepped = value;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: one bit per clock, start/done handshake.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : shift_if.slave (start/op/data_in/amount in; result/busy/done out)
// result is the working register; valid when done is high and afterwards
// until the next accept. Optional macro SHIFT_ROTATE_EN enables ROL/ROR.
module shift_unit #(
   parameter int unsigned WIDTH = shift_pkg::WIDTH,
   parameter int unsigned AMT_W = shift_pkg::AMT_W
) (
   input  logic    clk,
   input  logic    reset,
   shift_if.slave  bus
);
   import shift_pkg::*;

   state_e           state_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] work_q;
   logic [AMT_W-1:0] count_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] work_step;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op      (op_q),
      .value   (work_q),
      .stepped (work_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OP_LOAD;
         work_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  work_q <= bus.data_in;
                  busy_q <= 1'b1;
                  if (uses_amount(bus.op) && (bus.amount != '0)) begin
                     count_q <= bus.amount;
                     state_q <= StShift;
                  end else begin
                     // LOAD-like ops and zero amounts finish without stepping.
                     count_q <= '0;
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StShift: begin
               work_q  <= work_step;
               count_q <= count_q - AMT_W'(1);
               if (count_q == AMT_W'(1)) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.result = work_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: a behavioural model (whole-shift
// arithmetic plus a busy countdown) checked every cycle, directed literal
// cases, an abort-by-reset case and randomized traffic.
module tb_shift_unit;
   import shift_pkg::*;

   logic clk;
   logic reset;

   shift_if bus ();

   shift_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int eff_amount(input logic [2:0] op, input logic [4:0] a);
      case (op)
         3'b001, 3'b010, 3'b011: return int'(a);
`ifdef SHIFT_ROTATE_EN
         3'b100, 3'b101: return int'(a);
`endif
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] d,
                                              input logic [4:0] a);
      int s;
      s = int'(a);
      case (op)
         3'b001: return d << s;
         3'b010: return d >> s;
         3'b011: return $signed(d) >>> s;
`ifdef SHIFT_ROTATE_EN
         3'b100: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
         3'b101: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`endif
         default: return d;
      endcase
   endfunction

   // m_left: cycles of busy still to come (done shows in the last one).
   int          m_left   = 0;
   logic [31:0] m_result = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left   <= 0;
         m_result <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end else if (bus.start) begin
         m_left   <= eff_amount(bus.op, bus.amount) + 1;
         m_result <= ref_result(bus.op, bus.data_in, bus.amount);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("busy", 32'(bus.busy), 32'(m_left > 0));
         chk("done", 32'(bus.done), 32'(m_left == 1));
         if (m_left <= 1) chk("result", bus.result, m_result);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] a, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int busy_cnt;
      lat      = 0;
      busy_cnt = 0;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.data_in = d;
      bus.amount  = a;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            lat = i;
            chk({name, "_result"}, bus.result, exp_res);
            break;
         end
         @(negedge clk);
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.op      = 3'b000;
      bus.data_in = '0;
      bus.amount  = '0;
      #2;
      chk("reset_result", bus.result, 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_done", 32'(bus.done), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      run_op("sll4", 3'b001, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
      run_op("sra31", 3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
      run_op("srl31", 3'b010, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
      run_op("sll31", 3'b001, 32'h0000_0003, 5'd31, 32'h8000_0000, 32);
      run_op("sll0", 3'b001, 32'h1234_5678, 5'd0, 32'h1234_5678, 1);
      run_op("load", 3'b000, 32'hCAFE_F00D, 5'd9, 32'hCAFE_F00D, 1);
      run_op("op111", 3'b111, 32'h0BAD_BEEF, 5'd7, 32'h0BAD_BEEF, 1);
`ifdef SHIFT_ROTATE_EN
      run_op("ror1", 3'b101, 32'h0000_0003, 5'd1, 32'h8000_0001, 2);
      run_op("rol4", 3'b100, 32'hF000_0001, 5'd4, 32'h0000_001F, 5);
`else
      run_op("ror1", 3'b101, 32'h0000_0003, 5'd1, 32'h0000_0003, 1);
      run_op("rol4", 3'b100, 32'hF000_0001, 5'd4, 32'hF000_0001, 1);
`endif

      // start held high: back-to-back accepts, start during SHIFT ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'b001;
      for (int i = 0; i < 24; i++) begin
         bus.data_in = $urandom;
         bus.amount  = 5'(i % 3);
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (4) @(negedge clk);

      // Abort: reset in the middle of a 10-step SLL.
      bus.start   = 1'b1;
      bus.op      = 3'b001;
      bus.data_in = 32'h0000_0001;
      bus.amount  = 5'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_result", bus.result, 32'h0);
      chk("abort_busy", 32'(bus.busy), 32'h0);
      chk("abort_done", 32'(bus.done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      run_op("post_abort", 3'b001, 32'h0000_0001, 5'd2, 32'h0000_0004, 3);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 500; i++) begin
         bus.start   = ($urandom % 4) != 0;
         bus.op      = 3'($urandom);
         bus.data_in = $urandom;
         bus.amount  = ($urandom % 2 == 0) ? 5'($urandom % 4) : 5'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
